ltc23xx_multi_adc: RTL
======================

Name: ltc23xx_multi_adc

Overview:
- Parametrised successor to the team's fixed 4-channel, 16-bit LTC2324-16 driver; drives any LTC232x-family simultaneous-sampling SAR ADC (CNV/SCK, one SDO lane per channel).
- Fully synchronous to clk: SCK is a divided, registered clock, never gated.
- Adds a programmable sample period, one-shot and continuous modes, a valid/ready output stream and overrun accounting.
- Output feeds the DMA/AXIS packer.

Parameters:
NUM_CH, 4, number of SDO lanes/channels (1..8)
DATA_W, 16, bits per conversion (12..18)
CNVH_CYC, 4, CNV high time in clk cycles (>=1)
CONV_CYC, 25, conversion wait after CNV falls, in clk cycles (>=1)
SCK_HALF, 1, SCK half-period in clk cycles (>=1)
PERIOD_CYC, 110, continuous-mode frame period in clk cycles, measured CNV rise to CNV rise
OVR_W, 8, overrun counter width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active high
CNV  out  1  ADC convert start, registered
SCK  out  1  ADC serial clock, registered, idles low
SDO  in  NUM_CH  serial data, bit i = channel i, already synchronised to clk
sample_en  in  1  continuous mode enable
trig  in  1  one-shot request, single-cycle pulse
busy  out  1  frame in progress (any state except IDLE)
m_valid  out  1  frame available
m_ready  in  1  downstream accepts frame
m_data  out  NUM_CH*DATA_W  packed frame; channel i in bits [i*DATA_W +: DATA_W], MSB first per channel
ovr_flag  out  1  sticky: at least one frame dropped
ovr_clr  in  1  clears ovr_flag and ovr_cnt
ovr_cnt  out  OVR_W  dropped-frame count, saturating

Behaviour:
- Reset: state IDLE. CNV, SCK, busy, m_valid, ovr_flag = 0. m_data = 0. ovr_cnt = 0. All counters = 0.
- Reset mid-frame aborts immediately. The partial frame is discarded. CNV and SCK drop at once (asynchronous).
- States:
  - IDLE -> CNVH when sample_en=1 or trig=1.
  - CNVH: CNV=1 for exactly CNVH_CYC cycles -> CONV.
  - CONV: CNV=0 for CONV_CYC cycles -> SHIFT.
  - SHIFT: DATA_W SCK periods, each SCK_HALF cycles low then SCK_HALF cycles high; SCK=0 on exit -> WAIT.
  - WAIT -> CNVH when the period counter reaches PERIOD_CYC-1 and sample_en=1; -> IDLE when sample_en=0.
- Capture: on the last clk cycle of each SCK-high half, all lanes shift left with the SDO bit. The first bit captured is the MSB.
- Completion: after the DATA_W-th capture, the shift registers transfer to the output stage on the next cycle (frame-done).
- Period counter: starts at 0 on the cycle CNV rises and runs through the frame.
- Minimum frame length is F = CNVH_CYC + CONV_CYC + 2*SCK_HALF*DATA_W + 1. If PERIOD_CYC < F, WAIT lasts 1 cycle and the period stretches to F+1. No error is flagged.
- Defaults: F = 4+25+32+1 = 62; period 110 cycles = 1 Msps at 110 MHz.
- sample_en falling mid-frame: the current frame completes and is delivered normally, then the block goes to IDLE. This differs from the LTC2324-16 driver, which truncates CNV.
- trig: accepted only in IDLE; ignored when busy=1. trig with sample_en=1 in IDLE is the same as a sample_en start.
- Output handshake:
  - A transfer occurs when m_valid and m_ready are both 1.
  - m_data is stable while m_valid=1 and m_ready=0.
  - m_valid rises the cycle after frame-done and falls the cycle after the transfer unless a new frame loads that same cycle.
  - frame-done while m_valid=1 and m_ready=1 in the same cycle: the new frame loads and m_valid stays 1. Not an overrun.
- Overrun:
  - frame-done while m_valid=1 and m_ready=0: the new frame is dropped and m_data keeps the old frame.
  - On each drop: ovr_flag <= 1 and ovr_cnt increments, saturating at all-ones.
  - ovr_clr clears both. ovr_clr coinciding with a drop: the clear wins, then ovr_flag=1 and ovr_cnt=1 on the following cycle… (simplified rule: the result that cycle is ovr_flag=1, ovr_cnt=1).
- CNV and SCK are never high at the same time. SCK toggles only in SHIFT.

Test Plan:
1. Defaults, SDO lanes driving 0xA5C3, 0x1234, 0xFFFF, 0x0001 MSB first, sample_en=1, m_ready=1 -> CNV high 4 cycles every 110 cycles; 16 SCK pulses per frame; m_data = {0x0001, 0xFFFF, 0x1234, 0xA5C3}; m_valid rises 62 cycles after CNV rise.
2. One-shot: trig pulse in IDLE with sample_en=0 -> exactly one frame; busy high 62 cycles; trig pulses while busy produce no second frame.
3. Backpressure: m_ready=0 for 3 full frames -> m_data holds frame 1; ovr_cnt=2; ovr_flag=1; ovr_clr -> ovr_cnt=0, ovr_flag=0.
4. PERIOD_CYC=40 (below F=62) -> CNV rise-to-rise spacing is 63 cycles and data stays correct.
5. NUM_CH=2, DATA_W=18, SCK_HALF=2 -> 18 SCK periods of 4 cycles each; 36-bit m_data packed correctly.
6. rst asserted mid-SHIFT -> CNV=SCK=m_valid=0 immediately; after release with sample_en=1, the first CNV starts a clean frame with correct data.

Source files
------------

// File: rtl/ltc23xx_multi_adc.sv
// ltc23xx_multi_adc: LTC232x-family simultaneous-sampling SAR ADC driver with stream output and overrun accounting
// Ports: clk/rst (async active-high) | CNV, SCK to ADC; SDO lanes from ADC (one per channel, pre-synchronised)
//        sample_en (continuous), trig (one-shot), busy | m_valid/m_ready/m_data output stream
//        ovr_flag/ovr_cnt dropped-frame status, ovr_clr clears both
module ltc23xx_multi_adc #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 16,
    parameter int CNVH_CYC   = 4,
    parameter int CONV_CYC   = 25,
    parameter int SCK_HALF   = 1,
    parameter int PERIOD_CYC = 110,
    parameter int OVR_W      = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     CNV,
    output logic                     SCK,
    input  logic [NUM_CH-1:0]        SDO,
    input  logic                     sample_en,
    input  logic                     trig,
    output logic                     busy,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [NUM_CH*DATA_W-1:0] m_data,
    output logic                     ovr_flag,
    input  logic                     ovr_clr,
    output logic [OVR_W-1:0]         ovr_cnt
);
    localparam int FRAME = CNVH_CYC + CONV_CYC + 2 * SCK_HALF * DATA_W + 1;
    localparam int PMAX  = PERIOD_CYC > FRAME ? PERIOD_CYC : FRAME;
    localparam int CMAX0 = CNVH_CYC > CONV_CYC ? CNVH_CYC : CONV_CYC;
    localparam int CMAX  = CMAX0 > 2 * SCK_HALF ? CMAX0 : 2 * SCK_HALF;
    localparam int CW    = $clog2(CMAX + 1);
    localparam int BW    = $clog2(DATA_W);
    localparam int PW    = $clog2(PMAX + 2);
    localparam logic [CW-1:0] CNVH_LAST = CW'(CNVH_CYC - 1);
    localparam logic [CW-1:0] CONV_LAST = CW'(CONV_CYC - 1);
    localparam logic [CW-1:0] SCK_HI    = CW'(SCK_HALF);
    localparam logic [CW-1:0] SCK_LAST  = CW'(2 * SCK_HALF - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
    localparam logic [PW-1:0] PER_LAST  = PW'(PERIOD_CYC - 1);

    typedef enum logic [2:0] {IDLE, CNVH, CONV, SHIFT, WAIT} state_t;

    state_t                     state, state_n;
    logic [CW-1:0]              cnt, cnt_n;
    logic [BW-1:0]              bcnt, bcnt_n;
    logic [PW-1:0]              pcnt;
    logic [NUM_CH*DATA_W-1:0]   sh;
    logic                       done, cap, load, drop;

    assign busy = state != IDLE;
    assign cap  = state == SHIFT && cnt == SCK_LAST;
    assign load = done && (!m_valid || m_ready);
    assign drop = done && m_valid && !m_ready;

    // done is high on the first WAIT cycle; holding WAIT through it guarantees
    // at least one full WAIT cycle, so a too-short period stretches to FRAME+1
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        bcnt_n  = bcnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (sample_en || trig) state_n = CNVH;
            end
            CNVH: if (cnt == CNVH_LAST) begin
                state_n = CONV;
                cnt_n   = '0;
            end
            CONV: if (cnt == CONV_LAST) begin
                state_n = SHIFT;
                cnt_n   = '0;
            end
            SHIFT: if (cnt == SCK_LAST) begin
                cnt_n   = '0;
                bcnt_n  = bcnt == BIT_LAST ? '0 : bcnt + 1'b1;
                state_n = bcnt == BIT_LAST ? WAIT : SHIFT;
            end
            WAIT: begin
                cnt_n = '0;
                if (!sample_en) state_n = IDLE;
                else if (!done && pcnt >= PER_LAST) state_n = CNVH;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bcnt     <= '0;
            pcnt     <= '0;
            CNV      <= 1'b0;
            SCK      <= 1'b0;
            sh       <= '0;
            done     <= 1'b0;
            m_valid  <= 1'b0;
            m_data   <= '0;
            ovr_flag <= 1'b0;
            ovr_cnt  <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bcnt     <= bcnt_n;
            pcnt     <= (state_n == CNVH && state != CNVH) ? '0 : busy ? pcnt + 1'b1 : pcnt;
            CNV      <= state_n == CNVH;
            SCK      <= state_n == SHIFT && cnt_n >= SCK_HI;
            done     <= cap && bcnt == BIT_LAST;
            for (int i = 0; i < NUM_CH; i++)
                if (cap) sh[i*DATA_W +: DATA_W] <= {sh[i*DATA_W +: DATA_W-1], SDO[i]};
            m_valid  <= load || (m_valid && !m_ready);
            if (load) m_data <= sh;
            ovr_flag <= drop ? 1'b1 : ovr_clr ? 1'b0 : ovr_flag;
            ovr_cnt  <= drop ? (ovr_clr ? OVR_W'(1) : &ovr_cnt ? ovr_cnt : ovr_cnt + 1'b1)
                             : ovr_clr ? '0 : ovr_cnt;
        end
    end
endmodule
